// File: rtl/fmul_rr_sched_if.sv
// Signal bundle for fmul_rr_sched: requester operands, response port and multiplier link.
interface fmul_rr_sched_if #(
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23,
   parameter int unsigned NREQ   = 4
);
   localparam int unsigned W   = 1 + EXPO_W + MANT_W;
   localparam int unsigned IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ*2-1:0] req_rnd;
   logic              resp_valid;
   logic              resp_ready;
   logic [IDW-1:0]    resp_id;
   logic [W-1:0]      resp_res;
   logic [4:0]        resp_status;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic [1:0]        mul_rnd;
   logic [W-1:0]      mul_res;
   logic [4:0]        mul_status;
   logic              busy;

   // Environment side: requesters, response consumer and the shared multiplier.
   modport master (
      output req_valid, req_a, req_b, req_rnd, resp_ready, mul_res, mul_status,
      input  req_ready, resp_valid, resp_id, resp_res, resp_status, mul_a, mul_b, mul_rnd, busy
   );

   // Scheduler side.
   modport slave (
      input  req_valid, req_a, req_b, req_rnd, resp_ready, mul_res, mul_status,
      output req_ready, resp_valid, resp_id, resp_res, resp_status, mul_a, mul_b, mul_rnd, busy
   );
endinterface

// File: rtl/fmul_rr_sched.sv
// Round-robin scheduler sharing one pipelined FP multiplier among NREQ requesters.
// Issued ops are tracked by a tag pipe; results land in a response FIFO whose space is
// reserved up front by a credit counter, because the multiplier cannot be stalled.
module fmul_rr_sched #(
   parameter int unsigned EXPO_W = 8,
   parameter int unsigned MANT_W = 23,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned LAT    = 3,
   parameter int unsigned FIFO_D = 8
) (
   input logic            clk,
   input logic            rst,
   fmul_rr_sched_if.slave bus
);
   localparam int unsigned W   = 1 + EXPO_W + MANT_W;
   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(FIFO_D + 1);
   localparam int unsigned PW  = $clog2(FIFO_D);
   localparam int unsigned EW  = IDW + W + 5;

   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]   fifo_mem_q [FIFO_D];
   logic [EW-1:0]   fifo_mem_d [FIFO_D];
   logic [W-1:0]    mul_a_q, mul_a_d;
   logic [W-1:0]    mul_b_q, mul_b_d;
   logic [1:0]      mul_rnd_q, mul_rnd_d;
   // Stage LAT lines up with mul_res for the op issued LAT+1 edges earlier.
   logic [LAT:0]    tag_vld_q, tag_vld_d;
   logic [IDW-1:0]  tag_id_q [LAT+1];
   logic [IDW-1:0]  tag_id_d [LAT+1];

   logic [NREQ-1:0] req_ready;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  cand;
   logic            found;
   logic            can_issue;
   logic            issue;
   logic            push;
   logic            pop;
   logic            resp_valid;
   logic [EW-1:0]   head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_id  = '0;
      found     = 1'b0;
      cand      = '0;
      can_issue = (cnt_q < CW'(FIFO_D));
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDW'((32'(rr_ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found    = 1'b1;
            grant_id = cand;
         end
      end
      issue     = found && can_issue && !rst;
      req_ready = '0;
      if (issue) req_ready[grant_id] = 1'b1;
   end

   // Next-state: operand registers, tag pipe, credit count and FIFO bookkeeping.
   always_comb begin
      resp_valid = (occ_q != '0) && !rst;
      head       = fifo_mem_q[rd_ptr_q];
      push       = tag_vld_q[LAT];
      pop        = resp_valid && bus.resp_ready;

      rr_ptr_d  = issue ? grant_id : rr_ptr_q;
      mul_a_d   = issue ? bus.req_a[grant_id*W +: W] : mul_a_q;
      mul_b_d   = issue ? bus.req_b[grant_id*W +: W] : mul_b_q;
      mul_rnd_d = issue ? bus.req_rnd[grant_id*2 +: 2] : mul_rnd_q;

      tag_vld_d   = {tag_vld_q[LAT-1:0], issue};
      tag_id_d[0] = grant_id;
      for (int unsigned k = 1; k <= LAT; k++) tag_id_d[k] = tag_id_q[k-1];

      cnt_d = cnt_q;
      if (issue && !pop) cnt_d = cnt_q + 1'b1;
      else if (!issue && pop) cnt_d = cnt_q - 1'b1;

      occ_d = occ_q;
      if (push && !pop) occ_d = occ_q + 1'b1;
      else if (!push && pop) occ_d = occ_q - 1'b1;

      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      fifo_mem_d = fifo_mem_q;
      if (push) fifo_mem_d[wr_ptr_q] = {tag_id_q[LAT], bus.mul_res, bus.mul_status};
   end

   // Control state with synchronous reset; rr_ptr resets so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q  <= IDW'(NREQ - 1);
         cnt_q     <= '0;
         occ_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_rnd_q <= '0;
         tag_vld_q <= '0;
         for (int unsigned k = 0; k <= LAT; k++) tag_id_q[k] <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         mul_rnd_q <= mul_rnd_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   // FIFO storage needs no reset; validity is carried by the occupancy count.
   always_ff @(posedge clk) begin
      fifo_mem_q <= fifo_mem_d;
   end

   // Drive the interface outputs.
   always_comb begin
      bus.req_ready   = req_ready;
      bus.resp_valid  = resp_valid;
      bus.resp_id     = head[EW-1 -: IDW];
      bus.resp_res    = head[5 +: W];
      bus.resp_status = head[4:0];
      bus.mul_a       = mul_a_q;
      bus.mul_b       = mul_b_q;
      bus.mul_rnd     = mul_rnd_q;
      bus.busy        = (cnt_q != '0) && !rst;
   end
endmodule

// File: tb/tb_fmul_rr_sched.sv
// Directed bench for fmul_rr_sched with a behavioural LAT-stage multiplier stand-in.
module tb_fmul_rr_sched;
   localparam int unsigned NREQ   = 4;
   localparam int unsigned LAT    = 3;
   localparam int unsigned FIFO_D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fmul_rr_sched_if #(.EXPO_W(8), .MANT_W(23), .NREQ(NREQ)) bus ();

   fmul_rr_sched #(
      .EXPO_W(8), .MANT_W(23), .NREQ(NREQ), .LAT(LAT), .FIFO_D(FIFO_D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] a_arr [NREQ];
   logic [31:0] b_arr [NREQ];
   logic [1:0]  r_arr [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*32 +: 32] = a_arr[i];
         bus.req_b[i*32 +: 32] = b_arr[i];
         bus.req_rnd[i*2 +: 2] = r_arr[i];
      end
   end

   // Stand-in multiplier: fixed answers for the directed FP cases, a scramble otherwise.
   function automatic logic [36:0] fmodel(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] r);
      if (a == 32'hC040_0000 && b == 32'h4000_0000) return {32'hC0C0_0000, 5'b00000};
      if (a == 32'h7F80_0000 && b == 32'h0000_0000) return {32'h7FC0_0000, 5'b10000};
      return {a ^ {b[15:0], b[31:16]} ^ {30'b0, r}, a[4:0] ^ b[9:5]};
   endfunction

   logic [31:0] pa [LAT];
   logic [31:0] pb [LAT];
   logic [1:0]  pr [LAT];
   always @(posedge clk) begin
      pa[0] <= bus.mul_a;
      pb[0] <= bus.mul_b;
      pr[0] <= bus.mul_rnd;
      for (int k = 1; k < LAT; k++) begin
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
         pr[k] <= pr[k-1];
      end
   end
   always_comb {bus.mul_res, bus.mul_status} = fmodel(pa[LAT-1], pb[LAT-1], pr[LAT-1]);

   int n_chk  = 0;
   int n_pass = 0;
   int exp_cnt = 0;
   int exp_ptr = NREQ - 1;
   logic [38:0] sb [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // One cycle: inputs already driven at posedge+1; check grant, track issue and pop.
   task automatic step();
      logic [3:0]  er;
      logic [38:0] e;
      int          gi;
      bit          popped;
      #1;
      er = '0;
      gi = -1;
      if (exp_cnt < FIFO_D) begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (exp_ptr + k) % NREQ;
            if (gi < 0 && bus.req_valid[i]) gi = i;
         end
      end
      if (gi >= 0) er[gi] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      popped = bus.resp_valid && bus.resp_ready;
      if (gi >= 0) begin
         sb.push_back({2'(gi), fmodel(a_arr[gi], b_arr[gi], r_arr[gi])});
         exp_ptr = gi;
         exp_cnt++;
      end
      if (popped) begin
         chk("resp_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp_id", bus.resp_id, e[38:37]);
            chk("resp_res", bus.resp_res, e[36:5]);
            chk("resp_status", bus.resp_status, e[4:0]);
         end
         exp_cnt--;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 40 && (sb.size() != 0 || bus.busy); k++) step();
      chk("drain_sb_empty", sb.size(), 0);
      chk("drain_busy", bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = 32'h3F80_0000 + 32'(i);
         b_arr[i] = 32'h4000_0000 + 32'(3 * i);
         r_arr[i] = 2'(i);
      end
      bus.req_valid  = 4'hF;
      bus.resp_ready = 1'b1;
      rst            = 1'b1;

      // Reset: outputs quiet even with every requester asking.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 4'h0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_mul_a", bus.mul_a, 32'h0);
      chk("rst_mul_rnd", bus.mul_rnd, 2'h0);
      bus.req_valid = '0;
      rst           = 1'b0;
      @(posedge clk);
      #1;

      // 1. Single op from req0, LAT+2 latency.
      a_arr[0]      = 32'hC040_0000;
      b_arr[0]      = 32'h4000_0000;
      r_arr[0]      = 2'd0;
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      chk("t1_mul_a", bus.mul_a, 32'hC040_0000);
      chk("t1_mul_b", bus.mul_b, 32'h4000_0000);
      chk("t1_busy", bus.busy, 1);
      for (int k = 1; k <= LAT + 1; k++) begin
         chk("t1_resp_early", bus.resp_valid, 0);
         step();
      end
      chk("t1_resp_valid", bus.resp_valid, 1);
      chk("t1_resp_id", bus.resp_id, 2'd0);
      chk("t1_resp_res", bus.resp_res, 32'hC0C0_0000);
      chk("t1_resp_status", bus.resp_status, 5'b00000);
      step();
      chk("t1_idle_busy", bus.busy, 0);
      chk("t1_idle_valid", bus.resp_valid, 0);

      // 2. All valid, consumer always ready: one grant per cycle, no response bubbles.
      a_arr[0]      = 32'h3F80_0000;
      b_arr[0]      = 32'h4000_0000;
      bus.req_valid = 4'hF;
      for (int k = 0; k < 16; k++) begin
         if (k >= LAT + 2) chk("t2_no_bubble", bus.resp_valid, 1);
         step();
      end
      drain();

      // 3. Consumer stalled: exactly FIFO_D issues, head stable, one pop frees one slot.
      bus.req_valid  = 4'hF;
      bus.resp_ready = 1'b0;
      for (int k = 0; k < 14; k++) step();
      chk("t3_busy", bus.busy, 1);
      chk("t3_resp_valid", bus.resp_valid, 1);
      chk("t3_head_id", bus.resp_id, sb[0][38:37]);
      chk("t3_head_res", bus.resp_res, sb[0][36:5]);
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      step();
      step();
      chk("t3_refilled", exp_cnt, FIFO_D);

      // 4. Full credit with simultaneous pop and issue.
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 12; k++) step();
      drain();

      // 5. Reset with three ops in flight: stale results are dropped.
      bus.req_valid = 4'hF;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      #1;
      chk("t5_rst_ready", bus.req_ready, 4'h0);
      chk("t5_rst_resp_valid", bus.resp_valid, 0);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.req_valid = '0;
      sb.delete();
      exp_cnt = 0;
      exp_ptr = NREQ - 1;
      chk("t5_resp_valid", bus.resp_valid, 0);
      chk("t5_busy", bus.busy, 0);
      for (int k = 0; k < LAT + 4; k++) begin
         chk("t5_stale", bus.resp_valid, 0);
         step();
      end
      bus.req_valid = 4'hF;
      step();
      drain();

      // 6. inf * 0 from req2: invalid flag and result passed through untouched.
      a_arr[2]       = 32'h7F80_0000;
      b_arr[2]       = 32'h0000_0000;
      r_arr[2]       = 2'd0;
      bus.req_valid  = 4'b0100;
      bus.resp_ready = 1'b0;
      step();
      bus.req_valid = '0;
      for (int k = 0; k < 10 && !bus.resp_valid; k++) step();
      chk("t6_resp_valid", bus.resp_valid, 1);
      chk("t6_resp_id", bus.resp_id, 2'd2);
      chk("t6_status", bus.resp_status, 5'b10000);
      chk("t6_res", bus.resp_res, 32'h7FC0_0000);
      bus.resp_ready = 1'b1;
      step();
      chk("t6_busy", bus.busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
